// File: rtl/draw_sprite.sv
// draw_sprite: overlays a colour-keyed sprite, fetched from an external ROM, onto a video timing stream
// Ports:
//   pclk, rst_n                    pixel clock, asynchronous active-low reset
//   hcount_in, vcount_in           incoming 11-bit timing counters
//   hsync_in, vsync_in             incoming sync strobes
//   hblnk_in, vblnk_in             incoming blanking strobes
//   rgb_in                         background colour
//   xpos, ypos, enable             sprite top-left corner and visibility, latched at vblank start
//   mirror                         column flip, present only with DRAW_SPRITE_MIRROR_EN defined
//   pixel_addr, rgb_pixel          ROM address {row, column} out, ROM data back after ROM_LAT cycles
//   hcount_out .. rgb_out          timing and colour delayed by ROM_LAT+2 cycles
//   hit                            rgb_out carries a sprite pixel
// Optional feature macro: DRAW_SPRITE_MIRROR_EN
module draw_sprite #(
  parameter int          SPR_W     = 48,
  parameter int          SPR_H     = 64,
  parameter int          ADDR_XW   = 6,
  parameter int          ADDR_YW   = 6,
  parameter int          ROM_LAT   = 1,
  parameter logic [11:0] KEY_COLOR = 12'h000
) (
  input  logic                       pclk,
  input  logic                       rst_n,
  input  logic [10:0]                hcount_in,
  input  logic [10:0]                vcount_in,
  input  logic                       hsync_in,
  input  logic                       vsync_in,
  input  logic                       hblnk_in,
  input  logic                       vblnk_in,
  input  logic [11:0]                rgb_in,
  input  logic [11:0]                xpos,
  input  logic [11:0]                ypos,
  input  logic                       enable,
`ifdef DRAW_SPRITE_MIRROR_EN
  input  logic                       mirror,
`endif
  input  logic [11:0]                rgb_pixel,
  output logic [ADDR_YW+ADDR_XW-1:0] pixel_addr,
  output logic [10:0]                hcount_out,
  output logic [10:0]                vcount_out,
  output logic                       hsync_out,
  output logic                       vsync_out,
  output logic                       hblnk_out,
  output logic                       vblnk_out,
  output logic [11:0]                rgb_out,
  output logic                       hit
);
  typedef struct packed {
    logic [10:0] hc;
    logic [10:0] vc;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic [11:0] rgb;
    logic        ins;
  } stage_t;

  logic [11:0]                xs_q, ys_q;
  logic                       en_s_q, vb_prev_q;
  logic                       vb_edge;
  logic [12:0]                x_end, y_end;
  logic [ADDR_XW-1:0]         dx, col;
  logic [ADDR_YW-1:0]         dy;
  logic                       inside_d;
  logic [ADDR_YW+ADDR_XW-1:0] addr_d;
  stage_t                     stage_d, last;
  stage_t                     pipe_q [ROM_LAT+1];
  logic                       draw;
`ifdef DRAW_SPRITE_MIRROR_EN
  logic                       mir_q;
`endif

  assign vb_edge = vblnk_in & ~vb_prev_q;

  // placement is sampled once per frame so the sprite cannot tear mid-frame
  always_ff @(posedge pclk or negedge rst_n)
    if (!rst_n) begin
      xs_q      <= '0;
      ys_q      <= '0;
      en_s_q    <= 1'b0;
      vb_prev_q <= 1'b0;
`ifdef DRAW_SPRITE_MIRROR_EN
      mir_q     <= 1'b0;
`endif
    end else begin
      vb_prev_q <= vblnk_in;
      if (vb_edge) begin
        xs_q   <= xpos;
        ys_q   <= ypos;
        en_s_q <= enable;
`ifdef DRAW_SPRITE_MIRROR_EN
        mir_q  <= mirror;
`endif
      end
    end

  // bounds use 13-bit sums so a sprite placed near 4095 never wraps onto column/row 0
  always_comb begin
    x_end    = {1'b0, xs_q} + 13'(SPR_W);
    y_end    = {1'b0, ys_q} + 13'(SPR_H);
    inside_d = ({2'b00, hcount_in} >= {1'b0, xs_q}) && ({2'b00, hcount_in} < x_end) &&
               ({2'b00, vcount_in} >= {1'b0, ys_q}) && ({2'b00, vcount_in} < y_end);
    dx       = ADDR_XW'({1'b0, hcount_in} - xs_q);
    dy       = ADDR_YW'({1'b0, vcount_in} - ys_q);
`ifdef DRAW_SPRITE_MIRROR_EN
    col      = mir_q ? ADDR_XW'(SPR_W - 1) - dx : dx;
`else
    col      = dx;
`endif
    addr_d   = inside_d ? {dy, col} : '0;
    stage_d  = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in, inside_d};
  end

  // stage 0 issues the ROM address; ROM_LAT further stages keep timing aligned with rgb_pixel
  always_ff @(posedge pclk or negedge rst_n)
    if (!rst_n) begin
      pixel_addr <= '0;
      for (int i = 0; i <= ROM_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pixel_addr <= addr_d;
      pipe_q[0]  <= stage_d;
      for (int i = 1; i <= ROM_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end

  assign last = pipe_q[ROM_LAT];
  assign draw = last.ins & en_s_q & (rgb_pixel != KEY_COLOR) & ~last.hb & ~last.vb;

  always_ff @(posedge pclk or negedge rst_n)
    if (!rst_n) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
      hit        <= 1'b0;
    end else begin
      hcount_out <= last.hc;
      vcount_out <= last.vc;
      hsync_out  <= last.hs;
      vsync_out  <= last.vs;
      hblnk_out  <= last.hb;
      vblnk_out  <= last.vb;
      rgb_out    <= draw ? rgb_pixel : last.rgb;
      hit        <= draw;
    end
endmodule
